// File: rtl/capture_pkg.sv
// Shared encodings for the gated multi-channel capture buffer.
// State values and decimation mode selectors.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FETCH   = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    localparam int STATE_W = 3;

    localparam logic MODE_PICK = 1'b0;
    localparam logic MODE_AVG  = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// Single-port capture storage: synchronous write, registered read.
// Storage has no reset; the read register only updates on a read.
module capture_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2048
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/gated_capture_mc.sv
// Gate-qualified decimating capture of parallel ADC lanes into RAM,
// followed by a valid/ready readout of the stored words.
module gated_capture_mc
    import capture_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 2048,
    parameter int DECIMATE  = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_adc_init,
    input  logic                          i_arm,
    input  logic                          i_mode,
    input  logic                          i_stop,
    input  logic                          i_gate,
    input  logic [CHANNELS*DATA_SIZE-1:0] i_data,
    input  logic                          i_ready,
    output logic [CHANNELS*DATA_SIZE-1:0] o_data,
    output logic                          o_valid,
    output logic                          o_idle,
    output logic                          o_done,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int W  = CHANNELS * DATA_SIZE;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LD = $clog2(DECIMATE);
    localparam int DW = (LD > 0) ? LD : 1;
    localparam int SW = DATA_SIZE + LD;

    localparam logic [DW-1:0] DLAST = DW'(DECIMATE - 1);
    localparam logic [CW-1:0] CLAST = CW'(DEPTH - 1);

    state_t state, state_nx;

    logic          rst;
    logic          mode;
    logic [DW-1:0] dcnt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] count;
    logic          wr_pend;
    logic          stop_pend;
    logic [W-1:0]  wr_word;
    logic [W-1:0]  cap_word;
    logic [W-1:0]  ram_q;
    logic [AW-1:0] ram_addr;

    logic capturing, active, full_now, take, complete;
    logic stop_now, has_words, arm_go, accept, last;

    assign rst = i_reset || !i_adc_init;

    assign capturing = (state == ST_WAIT) || (state == ST_CAPTURE);
    assign active    = capturing && !stop_pend;
    assign full_now  = wr_pend && (count == CLAST);
    assign take      = active && i_gate && !full_now;
    assign complete  = take && (dcnt == DLAST);
    assign stop_now  = active && i_stop;
    assign has_words = wr_pend || (count != '0);
    assign arm_go    = (state == ST_IDLE) && i_arm;
    assign accept    = (state == ST_PRESENT) && i_ready;
    assign last      = ({1'b0, rd_addr} == count - CW'(1));

    always_ff @(posedge i_clock) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A stop that lands on a completing window waits one cycle
    // (stop_pend) so the pending word is written before readout.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (i_arm) state_nx = ST_WAIT;
            end
            ST_WAIT, ST_CAPTURE: begin
                if (full_now || stop_pend) begin
                    state_nx = ST_FETCH;
                end else if (stop_now) begin
                    if (complete)       state_nx = state;
                    else if (has_words) state_nx = ST_FETCH;
                    else                state_nx = ST_IDLE;
                end else if (i_gate) begin
                    state_nx = ST_CAPTURE;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            ST_FETCH: begin
                state_nx = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (i_ready) state_nx = last ? ST_IDLE : ST_FETCH;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (rst) begin
            mode      <= MODE_PICK;
            dcnt      <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            count     <= '0;
            wr_pend   <= 1'b0;
            stop_pend <= 1'b0;
            wr_word   <= '0;
        end else if (arm_go) begin
            mode      <= i_mode;
            dcnt      <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            count     <= '0;
            wr_pend   <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            if (wr_pend) begin
                count <= count + CW'(1);
                if (!full_now) wr_addr <= wr_addr + AW'(1);
            end
            wr_pend   <= complete;
            stop_pend <= stop_now && complete;
            if (complete) wr_word <= cap_word;
            dcnt <= (take && !complete) ? dcnt + DW'(1) : '0;
            if (capturing && state_nx == ST_FETCH) begin
                rd_addr <= '0;
            end else if (accept && !last) begin
                rd_addr <= rd_addr + AW'(1);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [SW-1:0]        acc;
        logic [SW-1:0]        sum;
        logic [SW-1:0]        shr;
        logic [DATA_SIZE-1:0] smp;

        assign smp = i_data[c*DATA_SIZE +: DATA_SIZE];
        assign sum = acc + SW'(smp);
        assign shr = sum >> LD;

        assign cap_word[c*DATA_SIZE +: DATA_SIZE] =
            (mode == MODE_AVG) ? shr[DATA_SIZE-1:0] : smp;

        // Any cycle that does not extend the window drops the partial sum.
        always_ff @(posedge i_clock) begin
            if (rst || arm_go) begin
                acc <= '0;
            end else if (take && !complete) begin
                acc <= sum;
            end else begin
                acc <= '0;
            end
        end
    end

    assign ram_addr = (state == ST_FETCH) ? rd_addr : wr_addr;

    capture_ram #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (i_clock),
        .we    (wr_pend),
        .re    (state == ST_FETCH),
        .addr  (ram_addr),
        .wdata (wr_word),
        .rdata (ram_q)
    );

    assign o_valid = (state == ST_PRESENT);
    assign o_data  = o_valid ? ram_q : '0;
    assign o_idle  = (state == ST_IDLE);
    assign o_done  = (state == ST_FETCH) || (state == ST_PRESENT);
    assign o_count = count;

endmodule

// File: tb/tb_gated_capture_mc.sv
// Directed bench for gated_capture_mc: DEPTH=4, DECIMATE=2, 2 lanes.
// Inputs change 1ns after the rising edge; outputs are read there too.
module tb_gated_capture_mc;

    localparam int DS = 8;
    localparam int CH = 2;
    localparam int DP = 4;
    localparam int DC = 2;
    localparam int W  = DS * CH;
    localparam int CW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          adc_init;
    logic          arm;
    logic          mode;
    logic          stop;
    logic          gate;
    logic          ready;
    logic [W-1:0]  data;
    logic [W-1:0]  odata;
    logic          ovalid;
    logic          oidle;
    logic          odone;
    logic [CW-1:0] ocount;

    int total = 0;
    int bad   = 0;
    int n;
    int done_bad;
    logic [W-1:0] got [16];
    logic [W-1:0] hold;
    logic         seen;

    always #5 clk = ~clk;

    gated_capture_mc #(
        .DATA_SIZE (DS),
        .CHANNELS  (CH),
        .DEPTH     (DP),
        .DECIMATE  (DC)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_adc_init (adc_init),
        .i_arm      (arm),
        .i_mode     (mode),
        .i_stop     (stop),
        .i_gate     (gate),
        .i_data     (data),
        .i_ready    (ready),
        .o_data     (odata),
        .o_valid    (ovalid),
        .o_idle     (oidle),
        .o_done     (odone),
        .o_count    (ocount)
    );

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_up(input logic m);
        arm  = 1'b1;
        mode = m;
        tick();
        arm  = 1'b0;
    endtask

    task automatic sample(input logic [7:0] c0, input logic [7:0] c1);
        gate = 1'b1;
        data = {c1, c0};
        tick();
    endtask

    function automatic logic [W-1:0] wexp(input int c0, input int c1);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(c0);
        b = 8'(c1);
        return {b, a};
    endfunction

    // Ramp capture in pick mode; ends one edge after the last sample.
    task automatic capture4(input int base);
        arm_up(1'b0);
        for (int k = 0; k < 8; k++) begin
            sample(8'(base + k), 8'(base + k + 100));
        end
        gate = 1'b0;
        tick();
    endtask

    task automatic collect(input int budget);
        ready    = 1'b1;
        n        = 0;
        done_bad = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ovalid) begin
                if (n < 16) got[n] = odata;
                n++;
                if (!odone) done_bad++;
            end
            if (oidle) break;
        end
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; adc_init = 1'b1; arm = 1'b0; mode = 1'b0;
        stop = 1'b0; gate = 1'b0; ready = 1'b0; data = '0;
        tick();
        tick();
        chk("rst_idle", oidle, 1);
        chk("rst_valid", ovalid, 0);
        chk("rst_count", ocount, 0);
        chk("rst_done", odone, 0);
        rst = 1'b0;
        tick();

        // pick-last ramp fills the buffer
        capture4(0);
        chk("pick_count", ocount, 4);
        chk("pick_done", odone, 1);
        chk("pick_fetch_valid", ovalid, 0);
        collect(40);
        chk("pick_n", n, 4);
        chk("pick_done_hi", done_bad, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pick_w%0d", i), got[i],
                wexp(2 * i + 1, 2 * i + 101));
        end
        chk("pick_end_idle", oidle, 1);
        chk("pick_count_hold", ocount, 4);

        // average mode, truncation and full-scale, then stop
        arm_up(1'b1);
        chk("arm_clears_count", ocount, 0);
        sample(8'd1, 8'd10);
        sample(8'd2, 8'd13);
        sample(8'd255, 8'd0);
        sample(8'd255, 8'd1);
        gate = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("avg_count", ocount, 2);
        collect(40);
        chk("avg_n", n, 2);
        chk("avg_w0", got[0], wexp(1, 11));
        chk("avg_w1", got[1], wexp(255, 0));

        // gate drop discards; stop on a completing window keeps it
        arm_up(1'b0);
        sample(8'h55, 8'h66);
        gate = 1'b0;
        tick();
        sample(8'h11, 8'h33);
        gate = 1'b1;
        data = {8'h44, 8'h22};
        stop = 1'b1;
        tick();
        stop = 1'b0;
        gate = 1'b0;
        tick();
        chk("drop_count", ocount, 1);
        collect(40);
        chk("drop_n", n, 1);
        chk("drop_w0", got[0], wexp(8'h22, 8'h44));

        // stop with nothing stored
        arm_up(1'b0);
        sample(8'd1, 8'd2);
        gate = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop0_idle", oidle, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= ovalid;
        end
        chk("stop0_novalid", seen, 0);
        chk("stop0_count", ocount, 0);

        // backpressure on the first word
        capture4(10);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (ovalid) seen = 1'b1;
            else tick();
        end
        chk("bp_valid", ovalid, 1);
        hold = odata;
        chk("bp_w0", hold, wexp(11, 111));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp_v%0d", i), ovalid, 1);
            chk($sformatf("bp_d%0d", i), odata, hold);
        end
        collect(40);
        chk("bp_n", n, 3);
        chk("bp_w1", got[0], wexp(13, 113));
        chk("bp_w2", got[1], wexp(15, 115));
        chk("bp_w3", got[2], wexp(17, 117));

        // reset mid-capture
        arm_up(1'b0);
        sample(8'd1, 8'd1);
        sample(8'd2, 8'd2);
        sample(8'd3, 8'd3);
        chk("mid_cap_count", ocount, 1);
        rst = 1'b1;
        tick();
        chk("rcap_idle", oidle, 1);
        chk("rcap_valid", ovalid, 0);
        chk("rcap_count", ocount, 0);
        rst  = 1'b0;
        gate = 1'b0;
        tick();

        // adc_init low mid-readout, then a fresh capture
        capture4(20);
        tick();
        chk("rrd_valid_pre", ovalid, 1);
        adc_init = 1'b0;
        tick();
        chk("rrd_idle", oidle, 1);
        chk("rrd_valid", ovalid, 0);
        chk("rrd_data", odata, 0);
        chk("rrd_count", ocount, 0);
        chk("rrd_done", odone, 0);
        adc_init = 1'b1;
        tick();
        capture4(40);
        collect(40);
        chk("rearm_n", n, 4);
        chk("rearm_w0", got[0], wexp(41, 141));
        chk("rearm_w3", got[3], wexp(47, 147));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
